// File: rtl/isa_pkg.sv
// Shared ISA definitions: instruction/address widths, opcode constants and
// the bit positions of each instruction field.
package isa_pkg;

    localparam int INSTR_W = 25;
    localparam int ADDR_W  = 8;

    localparam int OPC_W = 5;
    localparam int REG_W = 4;
    localparam int IMM_W = 8;

    localparam int OPC_MSB = 24;
    localparam int OPC_LSB = 20;
    localparam int DST_MSB = 19;
    localparam int DST_LSB = 16;
    localparam int S1_MSB  = 15;
    localparam int S1_LSB  = 12;
    localparam int S2_MSB  = 11;
    localparam int S2_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [OPC_W-1:0] OPC_NOP  = 5'd0;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'd1;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'd2;
    localparam logic [OPC_W-1:0] OPC_AND  = 5'd3;
    localparam logic [OPC_W-1:0] OPC_OR   = 5'd4;
    localparam logic [OPC_W-1:0] OPC_LDI  = 5'd5;
    localparam logic [OPC_W-1:0] OPC_LD   = 5'd6;
    localparam logic [OPC_W-1:0] OPC_ST   = 5'd7;
    localparam logic [OPC_W-1:0] OPC_JMP  = 5'd8;
    localparam logic [OPC_W-1:0] OPC_HALT = 5'd31;

endpackage

// File: rtl/inst_mem_if.sv
// Fetch bus between the program counter (master) and instruction memory (slave).
interface inst_mem_if;

    logic [isa_pkg::ADDR_W-1:0]  address;
    logic                        instRead;
    logic [isa_pkg::INSTR_W-1:0] data_out;
    logic [isa_pkg::OPC_W-1:0]   opcode;
    logic [isa_pkg::REG_W-1:0]   dest;
    logic [isa_pkg::REG_W-1:0]   source1;
    logic [isa_pkg::REG_W-1:0]   source2;
    logic [isa_pkg::IMM_W-1:0]   imm;

    modport master (
        output address, instRead,
        input  data_out, opcode, dest, source1, source2, imm
    );

    modport slave (
        input  address, instRead,
        output data_out, opcode, dest, source1, source2, imm
    );

endinterface

// File: rtl/instr_decode.sv
// Combinational field slicer for a 25-bit instruction word; shared with later
// pipeline stages.
module instr_decode
    import isa_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instr,
    output logic [OPC_W-1:0]   o_opcode,
    output logic [REG_W-1:0]   o_dest,
    output logic [REG_W-1:0]   o_source1,
    output logic [REG_W-1:0]   o_source2,
    output logic [IMM_W-1:0]   o_imm
);

    assign o_opcode  = i_instr[OPC_MSB:OPC_LSB];
    assign o_dest    = i_instr[DST_MSB:DST_LSB];
    assign o_source1 = i_instr[S1_MSB:S1_LSB];
    assign o_source2 = i_instr[S2_MSB:S2_LSB];
    assign o_imm     = i_instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/inst_mem.sv
// Read-only 256 x 25 instruction memory holding the boot program, with a
// registered read port and combinational field outputs.
module inst_mem
    import isa_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = INSTR_W
) (
    input  logic       clk,
    input  logic       reset,
    inst_mem_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    // The boot program is constant, so the array is a ROM table: "reloading"
    // on reset is inherent and needs no write path.
    function automatic logic [WIDTH-1:0] boot_word(input logic [AW-1:0] a);
        logic [WIDTH-1:0] w;
        case (a)
            8'd0:    w = 25'h0510005;   // LDI R1, #0x05
            8'd1:    w = 25'h0520003;   // LDI R2, #0x03
            8'd2:    w = 25'h0131200;   // ADD R3, R1, R2
            8'd3:    w = 25'h0241200;   // SUB R4, R1, R2
            8'd4:    w = 25'h1F00000;   // HALT
            default: w = 25'h0000000;   // NOP
        endcase
        return w;
    endfunction

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_rom_word;

    assign w_rom_word = boot_word(bus.address);

    // Output register: async clear discards any in-flight read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= 25'h0000000;
        end else if (bus.instRead) begin
            r_data <= w_rom_word;
        end else begin
            r_data <= r_data;
        end
    end

    assign bus.data_out = r_data;

    instr_decode u_decode (
        .i_instr   (r_data),
        .o_opcode  (bus.opcode),
        .o_dest    (bus.dest),
        .o_source1 (bus.source1),
        .o_source2 (bus.source2),
        .o_imm     (bus.imm)
    );

endmodule

// File: tb/tb_inst_mem.sv
// Scoreboard bench for inst_mem: expected words are queued as reads are issued
// and compared one cycle later.
module tb_inst_mem;
    import isa_pkg::*;

    logic clk;
    logic reset;

    inst_mem_if bus ();

    inst_mem #(.DEPTH(256), .WIDTH(25)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [24:0] exp_rom [256];
    logic [24:0] sb_q [$];
    logic [24:0] model_q;
    int          n_vec;
    int          n_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_data"}, {7'd0, bus.data_out}, 32'd0);
        check_val({tag, "_fld"}, {7'd0, bus.opcode, bus.dest, bus.source1, bus.source2, bus.imm}, 32'd0);
    endtask

    // Drive one fetch cycle, push the expected word, then check after the edge.
    task automatic step(input logic [7:0] a, input logic rd, input string tag);
        logic [24:0] exp;
        bus.address  = a;
        bus.instRead = rd;
        if (rd) model_q = exp_rom[a];
        sb_q.push_back(model_q);
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        check_val(tag, {7'd0, bus.data_out}, {7'd0, exp});
        check_val({tag, "_fld"},
                  {7'd0, bus.opcode, bus.dest, bus.source1, bus.source2, bus.imm},
                  {7'd0, exp});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) exp_rom[i] = 25'h0;
        exp_rom[0] = 25'h0510005;
        exp_rom[1] = 25'h0520003;
        exp_rom[2] = 25'h0131200;
        exp_rom[3] = 25'h0241200;
        exp_rom[4] = 25'h1F00000;

        // Reset held with reads requested: output stays cleared.
        reset        = 1'b0;
        bus.address  = 8'd0;
        bus.instRead = 1'b1;
        model_q      = 25'h0;
        #1;
        check_zero("rst_t0");
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        #2;
        reset = 1'b1;

        // Sequential fetch of the boot program.
        for (int i = 0; i < 5; i++) step(8'(i), 1'b1, "seq");
        step(8'd2, 1'b1, "add_word");
        check_val("add_opc", {27'd0, bus.opcode},  {27'd0, OPC_ADD});
        check_val("add_dst", {28'd0, bus.dest},    32'd3);
        check_val("add_s1",  {28'd0, bus.source1}, 32'd1);
        check_val("add_s2",  {28'd0, bus.source2}, 32'd2);
        check_val("add_imm", {24'd0, bus.imm},     32'd0);

        // Read-enable hold while the address moves.
        step(8'd0, 1'b1, "hold_rd0");
        for (int c = 0; c < 3; c++) step(8'd3, 1'b0, "hold");
        step(8'd3, 1'b1, "hold_rd3");

        // Unprogrammed and top-of-array addresses.
        step(8'd4, 1'b1, "pre_nop");
        step(8'd5, 1'b1, "nop_5");
        step(8'd4, 1'b1, "pre_top");
        step(8'd255, 1'b1, "nop_255");

        // Async reset between edges during a read of addr 4.
        step(8'd4, 1'b1, "pre_async");
        bus.address  = 8'd4;
        bus.instRead = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_clr");
        model_q = 25'h0;
        @(posedge clk);
        #1;
        check_zero("async_hold");
        #2;
        reset = 1'b1;
        step(8'd0, 1'b1, "post_rst");

        // Field mapping sweep, then back-to-back random reads.
        for (int i = 0; i < 5; i++) step(8'(i), 1'b1, "sweep");
        for (int i = 0; i < 20; i++)
            step(8'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rand");

        if (sb_q.size() != 0) check_val("sb_empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_mem.md
# inst_mem

Read-only instruction memory for the processor datapath. It holds 256 words of 25 bits, preloaded with a fixed boot program on reset. On a read-enabled clock edge it returns the addressed word, split into opcode, destination, source and immediate fields. It sits between the program counter (address source) and the decode/register-file stage.

## Interface

Parameters:
- `DEPTH`, 256: number of instruction words; fixed by the 8-bit address.
- `WIDTH`, 25: instruction word width.

Ports:
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `address`  input  8  word address of the instruction to fetch.
- `instRead`  input  1  read enable; sampled on the rising `clk` edge.
- `data_out`  output  25  registered instruction word.
- `opcode`  output  5  `data_out[24:20]`.
- `dest`  output  4  `data_out[19:16]`, destination register.
- `source1`  output  4  `data_out[15:12]`, first source register.
- `source2`  output  4  `data_out[11:8]`, second source register.
- `imm`  output  8  `data_out[7:0]`, immediate.

## Operation

- Storage is a 256 × 25 array. There is no write port.
- While `reset` is low, the array is loaded with the boot program and `data_out` is 0.
- Boot program (hex, 25-bit words):
  - addr 0 = 0x0510005: LDI R1, #0x05
  - addr 1 = 0x0520003: LDI R2, #0x03
  - addr 2 = 0x0131200: ADD R3, R1, R2
  - addr 3 = 0x0241200: SUB R4, R1, R2
  - addr 4 = 0x1F00000: HALT
  - addr 5–255 = 0 (NOP)
- Opcode encoding: NOP=0, ADD=1, SUB=2, AND=3, OR=4, LDI=5, LD=6, ST=7, JMP=8, HALT=31.
- Read: if `instRead`=1 at a rising edge, `data_out` takes `mem[address]`. If `instRead`=0, `data_out` holds its previous value.
- The five field outputs are purely combinational slices of `data_out`. They are therefore 0 during reset and always consistent with `data_out`.
- All 8-bit addresses are valid. There is no out-of-range condition and no wrap logic.

## Timing

- Read latency is 1 cycle: the address and `instRead` are presented before edge N, and the data is valid after edge N.
- The field outputs settle in the same cycle as `data_out`.
- Reset assertion clears `data_out` and the fields immediately, without waiting for a clock edge. It also reloads the boot program. This applies mid-read as well; an in-flight read is discarded.
- Reset deassertion takes effect at the next edge. On the first edge with `reset` high and `instRead`=1, the first word is delivered.
- If `address` changes while `instRead`=0, the outputs do not change.
- Back-to-back reads are allowed every cycle, with no bubbles.

## Structure

- Shared package `isa_pkg` holds:
  - the opcode constants;
  - the field bit positions and widths (OPC 24:20, DST 19:16, S1 15:12, S2 11:8, IMM 7:0);
  - `INSTR_W` = 25 and `ADDR_W` = 8.
- Optional sub-module `instr_decode`: a combinational slicer from `data_out` to the five fields, reusable by later pipeline stages.
- The boot program is a constant function or case table in the memory module.

## Test plan

- **Reset:** hold `reset`=0 for 2 cycles with `instRead`=1. Expect `data_out`=0 and all fields 0 throughout.
- **Sequential fetch:** release reset, set `instRead`=1, and step `address` 0..4, one per cycle. After each edge expect `data_out` = 0x0510005, 0x0520003, 0x0131200, 0x0241200, 0x1F00000. At addr 2 expect opcode=00001, dest=0011, source1=0001, source2=0010, imm=0x00.
- **Read-enable hold:** read addr 0, then set `instRead`=0 and `address`=3 for 3 cycles. Expect `data_out` to stay 0x0510005. Then raise `instRead`; expect 0x0241200 after the next edge.
- **Unprogrammed and boundary addresses:** read addr 5, then 255. Expect `data_out`=0 and all fields 0.
- **Async reset mid-run:** during a read of addr 4, drive `reset` low between clock edges. Expect `data_out` to become 0 before the next edge. After release, a read of addr 0 returns 0x0510005.
- **Field mapping sweep:** for each of addr 0–4, check that {opcode, dest, source1, source2, imm} equals `data_out` bit-for-bit.
